div_radix2: RTL and testbench

DIV_RADIX2 -- requirements
Module: div_radix2

---
 rtl/div_radix2.sv | 206 ++++++++++++++++++++
 tb/tb_div_radix2.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_radix2.sv
// -----------------------------------------------------------------------------
// div_radix2 -- iterative restoring radix-2 divider for the E stage (DIV/DIVU)
//
// Computes a 32-bit quotient and remainder. The operands are converted to
// magnitudes, one quotient bit is produced per cycle for 32 cycles, and the
// signs are applied on the final step. The result is registered into result_o
// as {remainder, quotient}, which maps directly onto {HI, LO}.
//
// Optional feature (macro DIV_ZERO_FAST_EN):
//   defined   : a zero divisor takes the short path FREE -> BY_ZERO -> END and
//               returns result_o = 0 with ready_o high two cycles after start.
//   undefined : there is no BY_ZERO state; a zero divisor runs the full 32
//               steps (magnitude quotient all ones, remainder = dividend).
//
// Ports
//   clk           in   1   clock, all state updates on the rising edge
//   rst           in   1   synchronous active-high reset
//   start_i       in   1   divide request (DIV/DIVU in E stage)
//   signed_div_i  in   1   1 = signed DIV, 0 = unsigned DIVU
//   opdata1_i     in  32   dividend (rs)
//   opdata2_i     in  32   divisor  (rt)
//   annul_i       in   1   flush; aborts any divide in progress
//   hold_i        in   1   E stage held by other stall sources
//   result_o      out 64   {remainder, quotient}
//   ready_o       out  1   result_o valid (registered, high only in END)
//   stateDbg      out  2   current FSM state encoding, for observation only
//
// Handshake: a request is taken when start_i=1 and annul_i=0 while the FSM
// is in FREE; the operands are captured on that edge and never looked at
// again. ready_o=1 marks result_o valid. The result is consumed on the first
// END cycle with hold_i=0, after which the FSM returns to FREE. annul_i
// cancels everything and wins over hold_i and over completion.
// -----------------------------------------------------------------------------
module div_radix2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  input  logic        hold_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic [1:0]  stateDbg
);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
`ifdef DIV_ZERO_FAST_EN
    BY_ZERO = 2'd1,
`endif
    ON      = 2'd2,
    END     = 2'd3
  } divState_e;

  divState_e   state;
  divState_e   stateNext;

  logic [4:0]  count;       // step index 0..31 while in ON
  logic [31:0] quo;         // dividend bits shift out the top, quotient bits shift in
  logic [31:0] rem;         // partial remainder magnitude
  logic [31:0] divisorMag;
  logic        negQuo;      // operand signs differ (signed mode only)
  logic        negRem;      // dividend negative (signed mode only)

  logic        startAccept;
  logic        op1Neg;
  logic        op2Neg;
  logic [31:0] op1Mag;
  logic [31:0] op2Mag;
  logic [32:0] partial;
  logic        subOk;
  logic [31:0] remStep;
  logic [31:0] quoStep;
  logic [63:0] finalResult;

  assign stateDbg = state;

  // ---------------------------------------------------------------------------
  // Operand capture helpers
  // ---------------------------------------------------------------------------
  assign startAccept = (state == FREE) && start_i && !annul_i;
  assign op1Neg      = signed_div_i & opdata1_i[31];
  assign op2Neg      = signed_div_i & opdata2_i[31];
  // Two's-complement negate; 0x80000000 maps to itself, which is the correct
  // unsigned magnitude 2^31.
  assign op1Mag      = op1Neg ? (~opdata1_i + 32'd1) : opdata1_i;
  assign op2Mag      = op2Neg ? (~opdata2_i + 32'd1) : opdata2_i;

  // ---------------------------------------------------------------------------
  // One restoring step: shift the next dividend bit into the remainder and
  // try to subtract the divisor. The partial value is 33 bits wide because the
  // shifted remainder can exceed 32 bits before the subtract. When the
  // subtract succeeds the difference is below the divisor, so the low 32 bits
  // of the subtraction are exact.
  // ---------------------------------------------------------------------------
  assign partial = {rem, quo[31]};
  assign subOk   = (partial >= {1'b0, divisorMag});
  assign remStep = subOk ? (partial[31:0] - divisorMag) : partial[31:0];
  assign quoStep = {quo[30:0], subOk};

  // Sign correction applied on the value produced by the last step.
  assign finalResult = {(negRem ? (~remStep + 32'd1) : remStep),
                        (negQuo ? (~quoStep + 32'd1) : quoStep)};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FREE;
    end else begin
      state <= stateNext;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. annul_i is checked before hold_i and before the final
  // step so a flush always wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    case (state)
      FREE: begin
        if (start_i && !annul_i) begin
`ifdef DIV_ZERO_FAST_EN
          if (opdata2_i == 32'd0) begin
            stateNext = BY_ZERO;
          end else begin
            stateNext = ON;
          end
`else
          stateNext = ON;
`endif
        end
      end
`ifdef DIV_ZERO_FAST_EN
      BY_ZERO: begin
        if (annul_i) begin
          stateNext = FREE;
        end else begin
          stateNext = END;
        end
      end
`endif
      ON: begin
        if (annul_i) begin
          stateNext = FREE;
        end else if (count == 5'd31) begin
          stateNext = END;
        end
      end
      END: begin
        if (annul_i || !hold_i) begin
          stateNext = FREE;
        end
      end
      default: begin
        stateNext = FREE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs. ready_o is derived from the next state so
  // it is high exactly while the FSM sits in END. result_o is written only on
  // the edge that enters END, so it is stable throughout END and keeps its
  // value in FREE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= 5'd0;
      quo        <= 32'd0;
      rem        <= 32'd0;
      divisorMag <= 32'd0;
      negQuo     <= 1'b0;
      negRem     <= 1'b0;
      result_o   <= 64'd0;
      ready_o    <= 1'b0;
    end else begin
      ready_o <= (stateNext == END);
      if (startAccept) begin
        count      <= 5'd0;
        quo        <= op1Mag;
        rem        <= 32'd0;
        divisorMag <= op2Mag;
        negQuo     <= op1Neg ^ op2Neg;
        negRem     <= op1Neg;
      end else if ((state == ON) && !annul_i) begin
        quo   <= quoStep;
        rem   <= remStep;
        count <= count + 5'd1;
        if (count == 5'd31) begin
          result_o <= finalResult;
        end
      end
`ifdef DIV_ZERO_FAST_EN
      else if ((state == BY_ZERO) && !annul_i) begin
        result_o <= 64'd0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// -----------------------------------------------------------------------------
// tb_div_radix2 -- self-checking bench for div_radix2
//
// Expected results come from a behavioural model using plain integer division
// on 64-bit values (SystemVerilog / and % truncate toward zero and give the
// remainder the dividend's sign). Expected values are queued at request time
// and popped when ready_o is seen. Honors DIV_ZERO_FAST_EN for the zero-divisor
// expectations.
// -----------------------------------------------------------------------------
module tb_div_radix2;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic        hold_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic [1:0]  stateDbg;

  int          nVectors = 0;
  int          nErrors  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] lastExp;

  div_radix2 dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .hold_i       (hold_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stateDbg     (stateDbg)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
      return 64'd0;
`else
      // magnitude quotient is all ones, remainder magnitude is |a|; with the
      // sign rules this leaves remainder = a and quotient = 1 for negative a
      if (sgn && a[31]) return {a, 32'd1};
      return {a, 32'hFFFF_FFFF};
`endif
    end
    if (!sgn) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int expLatency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) return 2;
`endif
    return 33;
  endfunction

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVectors++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance to the next cycle; outputs are sampled and inputs driven 1ns after
  // the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic scrambleOps();
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
  endtask

  // Presents a request in the current cycle (cycle 0) and moves to cycle 1.
  task automatic startDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    start_i      = 1'b1;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    exp_q.push_back(refDiv(sgn, a, b));
    stepCycle();
    start_i = 1'b0;
  endtask

  // Steps until ready_o rises, scrambling operands meanwhile; bounded.
  task automatic waitReady(input logic scramble, output int steps);
    steps = 0;
    while (!ready_o && steps < 100) begin
      if (scramble) scrambleOps();
      stepCycle();
      steps++;
    end
  endtask

  // Full divide: latency, result, release to FREE, held result in FREE.
  task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b);
    int steps;
    startDiv(sgn, a, b);
    waitReady(1'b1, steps);
    check({tag, "_latency"}, 64'(steps + 1), 64'(expLatency(b)));
    lastExp = exp_q.pop_front();
    check({tag, "_result"}, result_o, lastExp);
    hold_i = 1'b0;
    stepCycle();
    check({tag, "_ready_drop"}, {63'd0, ready_o}, 64'd0);
    check({tag, "_free_hold"}, result_o, lastExp);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          steps;
    logic        sawReady;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;

    rst          = 1'b1;
    start_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    annul_i      = 1'b0;
    hold_i       = 1'b0;
    lastExp      = 64'd0;

    // reset state
    stepCycle();
    stepCycle();
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;
    stepCycle();

    // directed vectors
    runDiv("divu_100_7", 1'b0, 32'd100, 32'd7);
    runDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    runDiv("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    runDiv("divu_5_0", 1'b0, 32'd5, 32'd0);
    runDiv("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);
    runDiv("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    runDiv("divu_3_max", 1'b0, 32'd3, 32'hFFFF_FFFF);

    // annul in cycle 10 of a divide; result keeps the previous value
    startDiv(1'b0, 32'd1000, 32'd3);
    void'(exp_q.pop_back());
    sawReady = 1'b0;
    for (int i = 1; i < 10; i++) begin
      sawReady |= ready_o;
      stepCycle();
    end
    annul_i = 1'b1;
    stepCycle();
    annul_i = 1'b0;
    sawReady |= ready_o;
    check("annul_no_ready", {63'd0, sawReady}, 64'd0);
    check("annul_result_held", result_o, lastExp);
    runDiv("after_annul", 1'b0, 32'd1000, 32'd3);

    // annul in the same cycle as the last step
    startDiv(1'b0, 32'd77, 32'd5);
    void'(exp_q.pop_back());
    for (int i = 1; i < 32; i++) stepCycle();
    annul_i = 1'b1;
    stepCycle();
    annul_i = 1'b0;
    check("annul_last_step", {63'd0, ready_o}, 64'd0);
    check("annul_last_held", result_o, lastExp);

    // annul in FREE blocks a start
    start_i   = 1'b1;
    annul_i   = 1'b1;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    stepCycle();
    start_i = 1'b0;
    annul_i = 1'b0;
    waitReady(1'b0, steps);
    check("annul_free_ignored", {63'd0, ready_o}, 64'd0);

    // hold in END for 3 cycles, then release
    startDiv(1'b0, 32'd123456, 32'd789);
    waitReady(1'b1, steps);
    lastExp = exp_q.pop_front();
    check("hold_latency", 64'(steps + 1), 64'd33);
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      check("hold_ready", {63'd0, ready_o}, 64'd1);
      check("hold_result", result_o, lastExp);
    end
    hold_i = 1'b0;
    stepCycle();
    check("hold_release", {63'd0, ready_o}, 64'd0);

    // annul beats hold in END
    startDiv(1'b1, 32'hFFFF_0000, 32'd17);
    waitReady(1'b1, steps);
    lastExp = exp_q.pop_front();
    check("annul_hold_result", result_o, lastExp);
    hold_i  = 1'b1;
    annul_i = 1'b1;
    stepCycle();
    hold_i  = 1'b0;
    annul_i = 1'b0;
    check("annul_over_hold", {63'd0, ready_o}, 64'd0);

    // back-to-back with start held high
    start_i      = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    exp_q.push_back(refDiv(1'b0, 32'd100, 32'd7));
    stepCycle();
    waitReady(1'b0, steps);
    check("b2b_first_latency", 64'(steps + 1), 64'd33);
    check("b2b_first_result", result_o, exp_q.pop_front());
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    exp_q.push_back(refDiv(1'b0, 32'd9, 32'd3));
    stepCycle();
    check("b2b_free_gap", {63'd0, ready_o}, 64'd0);
    stepCycle();
    start_i = 1'b0;
    waitReady(1'b1, steps);
    check("b2b_second_latency", 64'(steps + 1), 64'd33);
    lastExp = exp_q.pop_front();
    check("b2b_second_result", result_o, lastExp);
    check("b2b_second_const", lastExp, 64'h0000_0000_0000_0003);
    stepCycle();

    // reset in cycle 15 of a divide
    startDiv(1'b0, 32'd999, 32'd10);
    void'(exp_q.pop_back());
    for (int i = 1; i < 15; i++) stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    check("midrst_ready", {63'd0, ready_o}, 64'd0);
    check("midrst_result", result_o, 64'd0);
    sawReady = 1'b0;
    for (int i = 0; i < 40; i++) begin
      stepCycle();
      sawReady |= ready_o;
      if (result_o !== 64'd0) sawReady = 1'b1;
    end
    check("midrst_quiet", {63'd0, sawReady}, 64'd0);
    runDiv("after_rst", 1'b1, 32'hFFFF_FF00, 32'hFFFF_FFF0);

    // randomized vectors
    for (int n = 0; n < 40; n++) begin
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 255));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      runDiv("rand", sgn, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nErrors);
    $finish;
  end

endmodule
